// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    // Every instruction is one 32-bit word, so the PC advances by 4 bytes.
    localparam int unsigned INSTR_BYTES = 4;

    // Widths of the fields stored in each queue entry. These match the
    // default core build. The top zero-extends or truncates to these widths.
    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    // RUN fetches sequentially. FAULT holds fetch until the next redirect.
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // One fetched instruction and the PC it came from.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO that holds fetched instructions between the
// instruction memory and decode. Flush empties it in a single cycle and
// takes precedence over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2   // power of two, at least 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wr_entry_i,
    output fetch_entry_t rd_entry_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // The extra MSB on each pointer tells a full queue apart from an empty one.
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    fetch_entry_t   mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A push is accepted when a slot is free, or when a pop frees one on the same edge.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    assign rd_entry_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Compute the next pointer values. Flush overrides push and pop.
    always_comb begin
        // NOTE: each output gets a default first, so no path leaves it unassigned. This prevents inferred latches.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments, so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Write the storage array. A flush discards the incoming push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset. The pointers decide validity, and the top masks the head while the queue is empty.
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry_i;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller. It fetches sequentially from a combinational
// instruction memory into a small queue, and handles execute redirects.
// Out-of-range or misaligned fetch addresses raise a sticky fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              QUEUE_DEPTH   = 2,
    parameter int unsigned              IMEM_BYTES    = 4096,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_instr,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    input  logic                     out_ready,
    output logic                     fault,
    output logic [ADDRESS_WIDTH-1:0] fault_pc,
    output logic [31:0]              instr_count
);

    // Highest byte address at which a whole instruction still fits.
    localparam logic [ADDRESS_WIDTH-1:0] LAST_PC = ADDRESS_WIDTH'(IMEM_BYTES - INSTR_BYTES);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                     fault_q, fault_d;
    logic [ADDRESS_WIDTH-1:0] fault_pc_q, fault_pc_d;
    logic [31:0]              count_q, count_d;

    logic         push;
    logic         pop;
    logic         pc_bad;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign pop    = out_valid && out_ready;
    assign pc_bad = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q > LAST_PC);

    assign push_entry.pc    = FETCH_ADDR_W'(fetch_pc_q);
    assign push_entry.instr = FETCH_DATA_W'(imem_instr);

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .wr_entry_i (push_entry),
        .rd_entry_o (head_entry),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

    // Next state and fetch decisions. Redirect outranks fetching and fault detection.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        count_d    = pop ? count_q + 32'd1 : count_q;
        push       = 1'b0;

        if (redirect_valid) begin
            state_d    = RUN;
            fetch_pc_d = redirect_pc;
        end else begin
            case (state_q)
                RUN: begin
                    if (pc_bad) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = fetch_pc_q;
                    end else if (!q_full || pop) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
                    end
                end
                FAULT: begin
                    // Fetch holds here. Queued entries keep draining through decode.
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State, PC, fault and counter registers. Reset overrides everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
        end
    end

    // The head is only meaningful while valid. Zero it otherwise so the outputs stay clean.
    assign out_valid   = !q_empty;
    assign out_pc      = out_valid ? ADDRESS_WIDTH'(head_entry.pc) : '0;
    assign out_instr   = out_valid ? DATA_WIDTH'(head_entry.instr) : '0;
    assign imem_addr   = fetch_pc_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios against literal
// expectations, then randomized traffic against a queue-based model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instruction memory: a distinct word for every address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0] + 16'h1357};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .instr_count    (instr_count)
    );

    // Behavioural model: a plain queue of {pc, instr} plus fetch bookkeeping.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_fault;
    logic [31:0] m_fault_pc;
    logic [31:0] m_count;

    function void model_step();
        bit pop;
        if (!rst_n) begin
            mq.delete();
            m_pc       = 32'h0;
            m_halted   = 1'b0;
            m_fault    = 1'b0;
            m_fault_pc = 32'h0;
            m_count    = 32'h0;
        end else begin
            pop = (mq.size() > 0) && out_ready;
            if (pop) m_count = m_count + 1;
            if (redirect_valid) begin
                mq.delete();
                m_pc     = redirect_pc;
                m_halted = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                if (!m_halted) begin
                    if (m_pc % 4 != 0 || m_pc > 32'd4092) begin
                        m_fault    = 1'b1;
                        m_fault_pc = m_pc;
                        m_halted   = 1'b1;
                    end else if (mq.size() < 2) begin
                        mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                        m_pc = m_pc + 4;
                    end
                end
            end
        end
    endfunction

    // Advance one clock. The model updates on the edge, and the caller then checks at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick(); tick();
        n_tests++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_pc !== 32'h0)      begin n_fail++; $display("FAIL reset out_pc: got %h want 0", out_pc); end
        n_tests++; if (out_instr !== 32'h0)   begin n_fail++; $display("FAIL reset out_instr: got %h want 0", out_instr); end
        n_tests++; if (fault !== 1'b0)        begin n_fail++; $display("FAIL reset fault: got %b want 0", fault); end
        n_tests++; if (fault_pc !== 32'h0)    begin n_fail++; $display("FAIL reset fault_pc: got %h want 0", fault_pc); end
        n_tests++; if (instr_count !== 32'h0) begin n_fail++; $display("FAIL reset instr_count: got %0d want 0", instr_count); end
        n_tests++; if (imem_addr !== 32'h0)   begin n_fail++; $display("FAIL reset imem_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'(4*i))
                begin n_fail++; $display("FAIL stream[%0d] out_pc: got v=%b %h want v=1 %h", i, out_valid, out_pc, 4*i); end
            n_tests++; if (out_instr !== mem_word(32'(4*i)))
                begin n_fail++; $display("FAIL stream[%0d] out_instr: got %h want %h", i, out_instr, mem_word(32'(4*i))); end
            n_tests++; if (instr_count !== 32'(i))
                begin n_fail++; $display("FAIL stream[%0d] instr_count: got %0d want %0d", i, instr_count, i); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b0;
        repeat (5) tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL stall head: got v=%b %h want v=1 0", out_valid, out_pc); end
        n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall imem_addr: got %h want 8", imem_addr); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'(4*i))
                begin n_fail++; $display("FAIL stall drain[%0d]: got v=%b %h want v=1 %h", i, out_valid, out_pc, 4*i); end
            tick();
        end
        n_tests++; if (instr_count !== 32'd3) begin n_fail++; $display("FAIL stall instr_count: got %0d want 3", instr_count); end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b0;
        repeat (3) tick();
        n_tests++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL redirect prefill imem_addr: got %h want 8", imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL redirect bubble out_valid: got %b want 0", out_valid); end
        n_tests++; if (instr_count !== 32'd1) begin n_fail++; $display("FAIL redirect counted handshake: got %0d want 1", instr_count); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin n_fail++; $display("FAIL redirect target: got v=%b %h want v=1 40", out_valid, out_pc); end
        n_tests++; if (out_instr !== mem_word(32'h40)) begin n_fail++; $display("FAIL redirect instr: got %h want %h", out_instr, mem_word(32'h40)); end
    endtask

    task automatic test_fault();
        do_reset();
        out_ready = 1'b1;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_tests++; if (fault !== 1'b1 || fault_pc !== 32'h42) begin n_fail++; $display("FAIL fault misaligned: got f=%b pc=%h want f=1 pc=42", fault, fault_pc); end
        repeat (3) tick();
        n_tests++; if (out_valid !== 1'b0 || imem_addr !== 32'h42) begin n_fail++; $display("FAIL fault hold: got v=%b addr=%h want v=0 addr=42", out_valid, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin n_fail++; $display("FAIL fault resume: got v=%b %h want v=1 10", out_valid, out_pc); end
        n_tests++; if (fault !== 1'b1 || fault_pc !== 32'h42) begin n_fail++; $display("FAIL fault sticky: got f=%b pc=%h want f=1 pc=42", fault, fault_pc); end
        tick();
        n_tests++; if (out_pc !== 32'h14) begin n_fail++; $display("FAIL fault resume next: got %h want 14", out_pc); end
    endtask

    task automatic test_range_end();
        do_reset();
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFF0;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'hFF0 + 32'(4*k))
                begin n_fail++; $display("FAIL range_end[%0d]: got v=%b %h want v=1 %h", k, out_valid, out_pc, 32'hFF0 + 32'(4*k)); end
        end
        tick();
        n_tests++; if (fault !== 1'b1 || fault_pc !== 32'h1000) begin n_fail++; $display("FAIL range_end fault: got f=%b pc=%h want f=1 pc=1000", fault, fault_pc); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL range_end no push: got v=%b want 0", out_valid); end
        // Drain in FAULT: fill to full at the top of memory, then release decode.
        do_reset();
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFF8;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'hFF8) begin n_fail++; $display("FAIL drain head0: got v=%b %h want v=1 ff8", out_valid, out_pc); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'hFFC) begin n_fail++; $display("FAIL drain head1: got v=%b %h want v=1 ffc", out_valid, out_pc); end
        tick();
        n_tests++; if (out_valid !== 1'b0 || fault !== 1'b1 || fault_pc !== 32'h1000)
            begin n_fail++; $display("FAIL drain end: got v=%b f=%b pc=%h want v=0 f=1 pc=1000", out_valid, fault, fault_pc); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80; out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0 || instr_count !== 32'h0) begin n_fail++; $display("FAIL mid_reset clear: got v=%b cnt=%0d want v=0 cnt=0", out_valid, instr_count); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_reset imem_addr: got %h want 0", imem_addr); end
        rst_n = 1'b1; redirect_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_fail++; $display("FAIL mid_reset restart: got v=%b %h want v=1 0", out_valid, out_pc); end
        tick();
        n_tests++; if (out_pc !== 32'h4) begin n_fail++; $display("FAIL mid_reset next: got %h want 4", out_pc); end
    endtask

    task automatic test_random();
        logic [31:0] e_pc, e_instr;
        bit          e_valid;
        for (int c = 0; c < 600; c++) begin
            rst_n          = ($urandom_range(0, 99) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'($urandom_range(0, 63)) * 4;
                1:       redirect_pc = 32'hFE0 + 32'($urandom_range(0, 7)) * 4;
                2:       redirect_pc = 32'($urandom_range(0, 4095));
                default: redirect_pc = 32'h2000;
            endcase
            tick();
            e_valid = (mq.size() > 0);
            e_pc    = e_valid ? mq[0].pc : 32'h0;
            e_instr = e_valid ? mq[0].instr : 32'h0;
            n_tests++; if (out_valid !== e_valid)     begin n_fail++; $display("FAIL rand[%0d] out_valid: got %b want %b", c, out_valid, e_valid); end
            n_tests++; if (out_pc !== e_pc)           begin n_fail++; $display("FAIL rand[%0d] out_pc: got %h want %h", c, out_pc, e_pc); end
            n_tests++; if (out_instr !== e_instr)     begin n_fail++; $display("FAIL rand[%0d] out_instr: got %h want %h", c, out_instr, e_instr); end
            n_tests++; if (imem_addr !== m_pc)        begin n_fail++; $display("FAIL rand[%0d] imem_addr: got %h want %h", c, imem_addr, m_pc); end
            n_tests++; if (fault !== m_fault)         begin n_fail++; $display("FAIL rand[%0d] fault: got %b want %b", c, fault, m_fault); end
            n_tests++; if (fault_pc !== m_fault_pc)   begin n_fail++; $display("FAIL rand[%0d] fault_pc: got %h want %h", c, fault_pc, m_fault_pc); end
            n_tests++; if (instr_count !== m_count)   begin n_fail++; $display("FAIL rand[%0d] instr_count: got %0d want %0d", c, instr_count, m_count); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_fault();
        test_range_end();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
